// File: rtl/sar_adc_if.sv
// Handshake and analog-control bundle between the SAR engine and its surroundings.
// The controller attaches as slave; the analog front end / bench attaches as master.
interface sar_adc_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             continuous;
  logic             comp_in;
  logic             sh_sample;
  logic             comp_cal;
  logic             comp_en_n;
  logic [WIDTH-1:0] dac_code;
  logic [WIDTH-1:0] result;
  logic             valid;
  logic             busy;

  modport master (
    output start, continuous, comp_in,
    input  sh_sample, comp_cal, comp_en_n, dac_code, result, valid, busy
  );

  modport slave (
    input  start, continuous, comp_in,
    output sh_sample, comp_cal, comp_en_n, dac_code, result, valid, busy
  );
endinterface

// File: rtl/sar_adc_controller.sv
// Successive-approximation engine: samples, runs one MSB-first bit trial per window,
// and presents the converted code with a one-cycle valid strobe.
module sar_adc_controller #(
  parameter int WIDTH         = 8,
  parameter int SAMPLE_CYCLES = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  sar_adc_if.slave bus
);

  localparam int T       = SETTLE_CYCLES + 2;
  localparam int CNT_MAX = (SAMPLE_CYCLES > T) ? SAMPLE_CYCLES : T;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SAMPLE, TRIAL, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [IW-1:0]    idx, idx_nxt;
  logic [WIDTH-1:0] part, part_nxt;
  logic             comp_meta, comp_s;

  logic             sample_nxt, en_n_nxt, valid_nxt, busy_nxt;
  logic [WIDTH-1:0] dac_nxt, result_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      part      <= '0;
      comp_meta <= 1'b0;
      comp_s    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      part      <= part_nxt;
      comp_meta <= bus.comp_in;
      comp_s    <= comp_meta;
    end
  end

  // The trial window covers the two synchronizer stages, so comp_s on the last
  // trial clock already reflects the code driven at the start of the window.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    part_nxt  = part;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = SAMPLE;
          cnt_nxt   = '0;
          idx_nxt   = IW'(WIDTH - 1);
          part_nxt  = '0;
        end
      end
      SAMPLE: begin
        if (cnt == CW'(SAMPLE_CYCLES - 1)) begin
          state_nxt = TRIAL;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      TRIAL: begin
        if (cnt == CW'(T - 1)) begin
          cnt_nxt       = '0;
          part_nxt[idx] = comp_s;
          if (idx == '0) state_nxt = DONE;
          else           idx_nxt   = idx - IW'(1);
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DONE: begin
        if (bus.continuous) begin
          state_nxt = SAMPLE;
          cnt_nxt   = '0;
          idx_nxt   = IW'(WIDTH - 1);
          part_nxt  = '0;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state and registered, so they line up
  // with the state they describe and never see an input combinationally.
  always_comb begin
    sample_nxt = (state_nxt == SAMPLE);
    en_n_nxt   = (state_nxt != TRIAL);
    busy_nxt   = (state_nxt == SAMPLE) || (state_nxt == TRIAL);
    valid_nxt  = (state_nxt == DONE);
    dac_nxt    = '0;
    result_nxt = bus.result;
    if (state_nxt == TRIAL) dac_nxt = part_nxt | (WIDTH'(1) << idx_nxt);
    if (state_nxt == DONE)  result_nxt = part_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.sh_sample <= 1'b0;
      bus.comp_cal  <= 1'b0;
      bus.comp_en_n <= 1'b1;
      bus.dac_code  <= '0;
      bus.result    <= '0;
      bus.valid     <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      bus.sh_sample <= sample_nxt;
      bus.comp_cal  <= sample_nxt;
      bus.comp_en_n <= en_n_nxt;
      bus.dac_code  <= dac_nxt;
      bus.result    <= result_nxt;
      bus.valid     <= valid_nxt;
      bus.busy      <= busy_nxt;
    end
  end

endmodule
